// File: rtl/mux4_rr_select.sv
// Round-robin select generator for a 4x1 mux: burst-limited grants, registered sel/grant.
// Optional per-channel beat statistics are built when MUX4_SEL_STATS_EN is defined.
module mux4_rr_select #(
   parameter int BURST_LEN = 4
`ifdef MUX4_SEL_STATS_EN
   ,
   parameter int STAT_W = 16
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          req,
   input  logic                out_ready,
   output logic [1:0]          sel,
   output logic                sel_valid,
   output logic [3:0]          grant,
   output logic                beat_last
`ifdef MUX4_SEL_STATS_EN
   ,
   input  logic                stat_clr,
   output logic [4*STAT_W-1:0] stat_beats
`endif
);

   localparam int CW = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [1:0]    sel_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [3:0]    grant_n;
   logic [1:0]    win;
   logic          any_req;
   logic          xfer;
   logic          release_now;

   // First requester after base, wrapping, with base itself checked last.
   function automatic logic [1:0] rr_pick(
      input logic [1:0] base,
      input logic [3:0] r
   );
      logic [2:0] sh;
      logic [7:0] dbl;
      logic [3:0] rot;
      logic [1:0] off;
      sh  = {1'b0, base} + 3'd1;
      dbl = {r, r} >> sh;
      rot = dbl[3:0];
      off = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (rot[k]) begin
            off = 2'(k);
         end
      end
      return base + 2'd1 + off;
   endfunction

   assign sel_valid = (state == GRANT);
   assign any_req   = |req;
   assign win       = rr_pick(sel, req);
   assign xfer      = sel_valid & req[sel] & out_ready;
   assign beat_last = xfer & (cnt == CNT_LAST);

   // A withdrawn owner has req[sel]=0, so the search naturally skips it;
   // a completed burst keeps the owner eligible as the last candidate.
   assign release_now = beat_last | (sel_valid & ~req[sel]);

   // Next-state: pick a winner from IDLE, or rotate/idle at a release edge.
   always_comb begin
      state_n = state;
      sel_n   = sel;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               state_n = GRANT;
               sel_n   = win;
               cnt_n   = '0;
            end
         end
         GRANT: begin
            if (release_now) begin
               cnt_n = '0;
               if (any_req) begin
                  sel_n = win;
               end else begin
                  state_n = IDLE;
               end
            end else if (xfer) begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // One-hot grant computed from the next owner so it can be registered.
   always_comb begin
      grant_n = 4'b0000;
      if (state_n == GRANT) begin
         unique case (sel_n)
            2'd0: grant_n = 4'b0001;
            2'd1: grant_n = 4'b0010;
            2'd2: grant_n = 4'b0100;
            2'd3: grant_n = 4'b1000;
            default: grant_n = 4'b0000;
         endcase
      end
   end

   // Arbiter state; sel resets to 3 so the first search begins at channel 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sel   <= 2'b11;
         cnt   <= '0;
         grant <= 4'b0000;
      end else begin
         state <= state_n;
         sel   <= sel_n;
         cnt   <= cnt_n;
         grant <= grant_n;
      end
   end

`ifdef MUX4_SEL_STATS_EN
   logic [STAT_W-1:0] stat_q [4];

   for (genvar i = 0; i < 4; i++) begin : g_stat
      // Saturating beat count for channel i; clear takes priority.
      always_ff @(posedge clk) begin
         if (reset || stat_clr) begin
            stat_q[i] <= '0;
         end else if (xfer && (sel == 2'(i)) && (stat_q[i] != '1)) begin
            stat_q[i] <= stat_q[i] + STAT_W'(1);
         end
      end
      assign stat_beats[i*STAT_W +: STAT_W] = stat_q[i];
   end
`endif

endmodule

// File: tb/tb_mux4_rr_select.sv
// Randomized bench for mux4_rr_select against an owner/beat-count reference model.
// Directed sequences pin the model with literal expectations first.
module tb_mux4_rr_select;

   localparam int BL = 4;
`ifdef MUX4_SEL_STATS_EN
   localparam int SW = 3;
   localparam int SMAX = (1 << SW) - 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = 4'h0;
   logic       out_ready = 1'b0;
   logic [1:0] sel;
   logic       sel_valid;
   logic [3:0] grant;
   logic       beat_last;
`ifdef MUX4_SEL_STATS_EN
   logic            stat_clr = 1'b0;
   logic [4*SW-1:0] stat_beats;
`endif

   int total = 0;
   int bad = 0;

   mux4_rr_select #(
      .BURST_LEN(BL)
`ifdef MUX4_SEL_STATS_EN
      ,
      .STAT_W(SW)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .out_ready(out_ready),
      .sel(sel),
      .sel_valid(sel_valid),
      .grant(grant),
      .beat_last(beat_last)
`ifdef MUX4_SEL_STATS_EN
      ,
      .stat_clr(stat_clr),
      .stat_beats(stat_beats)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: who owns the mux and how many beats it has used.
   bit m_known = 0;
   bit m_valid = 0;
   int m_sel = 3;
   int m_used = 0;
   int m_stats [4];
   bit m_beat;
   int m_w;

   function automatic int first_after(int base, logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(base + k) % 4]) return (base + k) % 4;
      end
      return -1;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_known = 1;
         m_valid = 0;
         m_sel = 3;
         m_used = 0;
         for (int i = 0; i < 4; i++) m_stats[i] = 0;
      end else if (m_known) begin
         m_beat = m_valid && req[m_sel] && out_ready;
`ifdef MUX4_SEL_STATS_EN
         if (stat_clr) begin
            for (int i = 0; i < 4; i++) m_stats[i] = 0;
         end else if (m_beat && m_stats[m_sel] < SMAX) begin
            m_stats[m_sel]++;
         end
`endif
         if (!m_valid) begin
            if (req != 4'h0) begin
               m_sel = first_after(m_sel, req);
               m_valid = 1;
               m_used = 0;
            end
         end else if ((m_beat && m_used == BL - 1) || !req[m_sel]) begin
            m_w = first_after(m_sel, req);
            if (m_w < 0) m_valid = 0;
            else m_sel = m_w;
            m_used = 0;
         end else if (m_beat) begin
            m_used++;
         end
      end
   end

   logic [1:0] s_sel;
   logic       s_valid;
   logic [3:0] s_grant;
   logic       s_bl;

   // Compare DUT against the model mid-cycle, after inputs have settled.
   always begin
      @(negedge clk);
      #2;
      s_sel = sel;
      s_valid = sel_valid;
      s_grant = grant;
      s_bl = beat_last;
      if (m_known) begin
         chk("sel", 32'(sel), 32'(m_sel));
         chk("sel_valid", 32'(sel_valid), 32'(m_valid));
         chk("grant", 32'(grant), m_valid ? 32'(1 << m_sel) : 32'd0);
         chk("beat_last", 32'(beat_last),
             32'(m_valid && req[m_sel] && out_ready && m_used == BL - 1));
`ifdef MUX4_SEL_STATS_EN
         for (int i = 0; i < 4; i++) begin
            chk("stat_beats", 32'(stat_beats[i*SW +: SW]), 32'(m_stats[i]));
         end
`endif
      end
   end

   task automatic cyc(bit r, logic [3:0] rq, bit rdy);
      @(negedge clk);
      reset = r;
      req = rq;
      out_ready = rdy;
      #3;
   endtask

   task automatic pin(string name, int s, int v, int g);
      chk({name, "_sel"}, 32'(s_sel), 32'(s));
      chk({name, "_valid"}, 32'(s_valid), 32'(v));
      chk({name, "_grant"}, 32'(s_grant), 32'(g));
   endtask

   initial begin
      // reset with all requesting, then pure rotation
      cyc(1, 4'hF, 1);
      cyc(1, 4'hF, 1);
      cyc(0, 4'hF, 1);
      pin("t1_reset", 3, 0, 0);
      for (int i = 0; i < 20; i++) begin
         cyc(0, 4'hF, 1);
         pin("t2_rot", (i / 4) % 4, 1, 1 << ((i / 4) % 4));
         chk("t2_last", 32'(s_bl), 32'(i % 4 == 3));
      end

      // single requester is regranted without a bubble
      cyc(1, 4'b0100, 1);
      cyc(0, 4'b0100, 1);
      pin("t3_idle", 3, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 4'b0100, 1);
         pin("t3_hold", 2, 1, 4'b0100);
         chk("t3_last", 32'(s_bl), 32'(i % 4 == 3));
      end

      // backpressure freezes the burst
      cyc(1, 4'b0011, 1);
      cyc(0, 4'b0011, 1);
      cyc(0, 4'b0011, 1);
      cyc(0, 4'b0011, 1);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 4'b0011, 0);
         pin("t4_stall", 0, 1, 1);
         chk("t4_stall_last", 32'(s_bl), 32'd0);
      end
      cyc(0, 4'b0011, 1);
      chk("t4_beat3_last", 32'(s_bl), 32'd0);
      cyc(0, 4'b0011, 1);
      chk("t4_beat4_last", 32'(s_bl), 32'd1);
      cyc(0, 4'b0011, 1);
      pin("t4_rotate", 1, 1, 4'b0010);

      // withdrawal hands over immediately, then idle when nobody asks
      cyc(1, 4'b1010, 1);
      cyc(0, 4'b1010, 1);
      cyc(0, 4'b1010, 1);
      pin("t5_ch1", 1, 1, 4'b0010);
      cyc(0, 4'b1010, 1);
      cyc(0, 4'b1000, 1);
      chk("t5_drop_last", 32'(s_bl), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 4'b1000, 1);
         pin("t5_ch3", 3, 1, 4'b1000);
         chk("t5_ch3_last", 32'(s_bl), 32'(i == 3));
      end
      cyc(0, 4'b0000, 1);
      cyc(0, 4'b0000, 1);
      pin("t5_idle", 3, 0, 0);

      // reset in the middle of a burst
      cyc(1, 4'b0100, 1);
      cyc(0, 4'b0100, 1);
      cyc(0, 4'b0100, 1);
      cyc(1, 4'b0100, 1);
      cyc(0, 4'b0100, 1);
      pin("t6_reset", 3, 0, 0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         logic [3:0] rq;
         rq = req;
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
         else if ($urandom_range(0, 5) == 0) rq[$urandom_range(0, 3)] ^= 1'b1;
`ifdef MUX4_SEL_STATS_EN
         stat_clr = ($urandom_range(0, 149) == 0);
`endif
         cyc($urandom_range(0, 299) == 0, rq, $urandom_range(0, 3) != 0);
      end

      cyc(0, 4'h0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
